control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Hardwired, parametrised control unit for the bus-based Datapath. Replaces the per-instruction
//  testbench FSMs: generates the T0..T7 control-step strobes (fetch + execute) for ld, ldi, st,
//  addi, andi, ori, nop and halt. It adds a memory-ready handshake with a timeout, an
//  instruction-boundary stop, and illegal-opcode trapping. Drives Datapath control inputs directly.
// PARAMETERS
//  OPC_W        5   opcode width, taken from IR[31:32-OPC_W]
//  CTRL_W       5   ALU CONTROL bus width
//  MEM_TIMEOUT  15  max cycles waiting for Mem_Ready before trap; >=1
//  TO_W         4   timeout counter width; must satisfy 2**TO_W > MEM_TIMEOUT
// PORTS
//  Clock      in   1       system clock, rising edge
//  Clear      in   1       synchronous active-high reset
//  Start      in   1       leave IDLE and begin fetching
//  Stop       in   1       request halt at the next instruction boundary
//  IR         in   32      instruction register contents (opcode decode)
//  Mem_Ready  in   1       memory completed the current Read/Write
//  CONTROL    out  CTRL_W  ALU operation select
//  IncPC, Read, Write, PC_Out, MDR_Out, ZLO_Out, C_Out, R_Out, BA_Out  out 1  datapath strobes
//  PC_In, MDR_In, MAR_In, IR_In, Y_In, ZLO_In, R_In, G_RA, G_RB        out 1  datapath strobes
//  Run        out  1       high in every state except IDLE and HALT
//  Illegal    out  1       sticky: undecodable opcode trapped
//  Mem_Err    out  1       sticky: Mem_Ready timeout trapped
// BEHAVIOUR
//  - Moore FSM. Outputs decode from the state register only and are valid for the whole cycle
//    the state is held. States: IDLE, T0..T7, HALT.
//  - Clear (sampled at a rising edge) forces IDLE. All strobes, CONTROL, Run, Illegal and Mem_Err
//    are 0 in the following cycle. This applies mid-instruction and mid-wait.
//  - IDLE: all strobes 0. Start=1 -> T0.
//  - Fetch (all opcodes):
//    - T0: PC_Out, MAR_In, IncPC.
//    - T1: Read, MDR_In. Held until Mem_Ready=1.
//    - T2: MDR_Out, IR_In.
//    Opcode is sampled from IR in T3 (IR is loaded at the end of T2).
//  - Opcodes: ld=0, ldi=1, st=2, addi=12, andi=13, ori=14, nop=30, halt=31. Any other -> HALT,
//    Illegal<=1.
//  - ld:
//    - T3: G_RB, BA_Out, Y_In.
//    - T4: C_Out, CONTROL=ADD, ZLO_In.
//    - T5: ZLO_Out, MAR_In.
//    - T6: Read, MDR_In (wait on Mem_Ready).
//    - T7: MDR_Out, G_RA, R_In.
//  - ldi: T3 and T4 as ld; T5: ZLO_Out, G_RA, R_In; then end.
//  - st:
//    - T3..T5 as ld.
//    - T6: G_RA, R_Out, MDR_In (Read=0, so MDR loads from the bus).
//    - T7: Write (wait on Mem_Ready).
//  - addi/andi/ori:
//    - T3: G_RB, R_Out, Y_In.
//    - T4: C_Out, CONTROL=ADD/AND/OR, ZLO_In.
//    - T5: ZLO_Out, G_RA, R_In; then end.
//  - nop ends after T3 (no strobes in T3). halt -> HALT from T3.
//  - End of instruction: next state T0, or HALT if Stop was seen high at any cycle since that
//    instruction's T0 (a latched stop request, cleared on entering T0).
//  - Wait states (T1, ld T6, st T7):
//    - Counter resets to 0 on entry and increments each cycle Mem_Ready=0.
//    - Mem_Ready=1 in the entry cycle gives zero added latency (state occupies 1 cycle).
//    - Counter reaching MEM_TIMEOUT with Mem_Ready=0 -> HALT, Mem_Err<=1, Read/Write drop the
//      next cycle.
//  - Mem_Ready outside a wait state is ignored. Start is ignored outside IDLE.
//  - HALT: all strobes 0, Run=0. Only Clear exits.
//  - Latency with Mem_Ready tied high:
//    - ldi/addi/andi/ori: 6 cycles.
//    - ld/st: 8 cycles.
//    - nop: 4 cycles.
// STRUCTURE
//  - Package cpu_ctrl_pkg: opcode localparams, ALU codes (ADD=0, AND=5'b00101, OR=5'b00110) and
//    the state enum encoding. Datapath and all benches share it.
//  - One sub-module, mem_wait_timer: counter, timeout compare, restart-on-entry.
//  - Remainder is the state register, next-state logic and the output decode.
// TESTING
//  1. ldi R1,85: IR=0x08800055, Mem_Ready=1, Start pulse.
//     -> T0..T5 in 6 cycles; T4 CONTROL=0 with C_Out,ZLO_In; T5 ZLO_Out,G_RA,R_In; back to T0.
//  2. ld with Mem_Ready delayed 3 cycles in T6.
//     -> Read and MDR_In held 4 cycles, then T7 MDR_Out,R_In; total 11 cycles.
//  3. st, IR=0x10000000 (opcode 2).
//     -> T6 R_Out,MDR_In with Read=0; T7 Write; Mem_Ready=1 -> T0 next.
//  4. Mem_Ready held 0 in T1 with MEM_TIMEOUT=15.
//     -> HALT after 16 T1 cycles; Mem_Err=1; Run=0; Read=0 after.
//  5. IR opcode 7 (undefined).
//     -> HALT in the cycle after T3, Illegal=1; Clear -> IDLE, Illegal=0.
//  6. Stop pulsed in T4 of addi, then Clear asserted mid-ld T6.
//     -> addi completes T5 then HALT; after the second Clear, all outputs 0 next cycle.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Package: cpu_ctrl_pkg
// Shared constants for the hardwired control sequencer and its Datapath:
//   - opcode values (compared zero-extended to 32 bits so OPC_W can vary)
//   - ALU CONTROL codes
//   - sequencer state encoding and the decoded instruction class
//   - helper functions: opcode -> class, class -> ALU code
package cpu_ctrl_pkg;

    localparam logic [31:0] OPC_LD   = 32'd0;
    localparam logic [31:0] OPC_LDI  = 32'd1;
    localparam logic [31:0] OPC_ST   = 32'd2;
    localparam logic [31:0] OPC_ADDI = 32'd12;
    localparam logic [31:0] OPC_ANDI = 32'd13;
    localparam logic [31:0] OPC_ORI  = 32'd14;
    localparam logic [31:0] OPC_NOP  = 32'd30;
    localparam logic [31:0] OPC_HALT = 32'd31;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_AND = 5'b00101;
    localparam logic [4:0] ALU_OR  = 5'b00110;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_T6   = 4'd7,
        ST_T7   = 4'd8,
        ST_HALT = 4'd9
    } state_e;

    typedef enum logic [3:0] {
        CLS_LD   = 4'd0,
        CLS_LDI  = 4'd1,
        CLS_ST   = 4'd2,
        CLS_ADDI = 4'd3,
        CLS_ANDI = 4'd4,
        CLS_ORI  = 4'd5,
        CLS_NOP  = 4'd6,
        CLS_HALT = 4'd7,
        CLS_ILL  = 4'd8
    } op_class_e;

    // Map a zero-extended opcode onto its instruction class.
    function automatic op_class_e decode_opcode(input logic [31:0] opc);
        op_class_e cls;
        case (opc)
            OPC_LD:   cls = CLS_LD;
            OPC_LDI:  cls = CLS_LDI;
            OPC_ST:   cls = CLS_ST;
            OPC_ADDI: cls = CLS_ADDI;
            OPC_ANDI: cls = CLS_ANDI;
            OPC_ORI:  cls = CLS_ORI;
            OPC_NOP:  cls = CLS_NOP;
            OPC_HALT: cls = CLS_HALT;
            default:  cls = CLS_ILL;
        endcase
        return cls;
    endfunction

    // ALU operation used in T4; address arithmetic of ld/ldi/st is an ADD.
    function automatic logic [4:0] alu_code(input op_class_e cls);
        logic [4:0] code;
        case (cls)
            CLS_ANDI: code = ALU_AND;
            CLS_ORI:  code = ALU_OR;
            default:  code = ALU_ADD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Module: mem_wait_timer
// Counts cycles spent waiting for Mem_Ready inside a memory wait state.
//   clk        in  system clock
//   clear      in  synchronous active-high reset
//   wait_en    in  sequencer currently sits in a wait state
//   mem_ready  in  memory completed the access
//   timeout    out counter has reached MEM_TIMEOUT and memory is still not ready
// The counter is held at zero whenever wait_en is low. Every wait state is
// entered from a non-wait state, so this restarts the count on each entry.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4
) (
    input  logic clk,
    input  logic clear,
    input  logic wait_en,
    input  logic mem_ready,
    output logic timeout
);

    logic [TO_W-1:0] cnt_r;
    logic            at_limit_s;

    assign at_limit_s = (cnt_r == TO_W'(MEM_TIMEOUT));
    assign timeout    = wait_en & ~mem_ready & at_limit_s;

    // Wait counter: zero outside wait states, +1 per not-ready cycle, saturates at the limit.
    always_ff @(posedge clk) begin
        if (clear) begin
            cnt_r <= {TO_W{1'b0}};
        end else if (!wait_en) begin
            cnt_r <= {TO_W{1'b0}};
        end else if (!mem_ready && !at_limit_s) begin
            cnt_r <= cnt_r + TO_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Module: control_sequencer
// Hardwired Moore control unit for the bus-based Datapath. Generates T0..T7
// control-step strobes for ld, ldi, st, addi, andi, ori, nop and halt, with a
// Mem_Ready handshake plus timeout, a Stop request honoured at instruction
// boundaries and illegal-opcode trapping.
// Ports:
//   Clock, Clear          clock, synchronous active-high reset
//   Start, Stop           leave IDLE / halt at the next instruction boundary
//   IR                    instruction register (opcode in IR[31:32-OPC_W])
//   Mem_Ready             memory access complete
//   CONTROL               ALU operation select
//   IncPC .. G_RB         datapath strobes
//   Run                   not IDLE and not HALT
//   Illegal, Mem_Err      sticky trap flags
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int OPC_W       = 5,
    parameter int CTRL_W      = 5,
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4
) (
    input  logic              Clock,
    input  logic              Clear,
    input  logic              Start,
    input  logic              Stop,
    input  logic [31:0]       IR,
    input  logic              Mem_Ready,
    output logic [CTRL_W-1:0] CONTROL,
    output logic              IncPC,
    output logic              Read,
    output logic              Write,
    output logic              PC_Out,
    output logic              MDR_Out,
    output logic              ZLO_Out,
    output logic              C_Out,
    output logic              R_Out,
    output logic              BA_Out,
    output logic              PC_In,
    output logic              MDR_In,
    output logic              MAR_In,
    output logic              IR_In,
    output logic              Y_In,
    output logic              ZLO_In,
    output logic              R_In,
    output logic              G_RA,
    output logic              G_RB,
    output logic              Run,
    output logic              Illegal,
    output logic              Mem_Err
);

    state_e          state_r;
    state_e          state_nxt_s;
    op_class_e       op_class_r;
    op_class_e       ir_class_s;
    op_class_e       cur_class_s;
    logic [OPC_W-1:0] opc_s;
    logic            stop_r;
    logic            end_halt_s;
    logic            wait_s;
    logic            timeout_s;
    logic            illegal_r;
    logic            mem_err_r;
    logic            unused_ir_s;

    assign opc_s       = IR[31:32-OPC_W];
    assign ir_class_s  = decode_opcode({{(32-OPC_W){1'b0}}, opc_s});
    assign unused_ir_s = ^IR[31-OPC_W:0];
    assign end_halt_s  = stop_r | Stop;
    assign Illegal     = illegal_r;
    assign Mem_Err     = mem_err_r;

    // IR becomes valid only at the T2->T3 edge, so T3 decodes IR directly;
    // later steps use the class captured at the end of T3.
    always_comb begin
        if (state_r == ST_T3) begin
            cur_class_s = ir_class_s;
        end else begin
            cur_class_s = op_class_r;
        end
    end

    // Wait states: fetch T1, ld T6, st T7.
    always_comb begin
        case (state_r)
            ST_T1:   wait_s = 1'b1;
            ST_T6:   wait_s = (cur_class_s == CLS_LD);
            ST_T7:   wait_s = (cur_class_s == CLS_ST);
            default: wait_s = 1'b0;
        endcase
    end

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TO_W        (TO_W)
    ) u_timer (
        .clk       (Clock),
        .clear     (Clear),
        .wait_en   (wait_s),
        .mem_ready (Mem_Ready),
        .timeout   (timeout_s)
    );

    // State register.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Instruction class capture at the end of T3.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            op_class_r <= CLS_NOP;
        end else if (state_r == ST_T3) begin
            op_class_r <= ir_class_s;
        end else begin
            op_class_r <= op_class_r;
        end
    end

    // Stop request latch; T0 restarts it so only this instruction's requests count.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            stop_r <= 1'b0;
        end else if (state_r == ST_T0) begin
            stop_r <= Stop;
        end else begin
            stop_r <= stop_r | Stop;
        end
    end

    // Sticky trap flags, cleared only by Clear.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            illegal_r <= 1'b0;
            mem_err_r <= 1'b0;
        end else begin
            illegal_r <= illegal_r | ((state_r == ST_T3) && (ir_class_s == CLS_ILL));
            mem_err_r <= mem_err_r | timeout_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: state_nxt_s = Start ? ST_T0 : ST_IDLE;
            ST_T0:   state_nxt_s = ST_T1;
            ST_T1: begin
                if (timeout_s) begin
                    state_nxt_s = ST_HALT;
                end else if (Mem_Ready) begin
                    state_nxt_s = ST_T2;
                end else begin
                    state_nxt_s = ST_T1;
                end
            end
            ST_T2:   state_nxt_s = ST_T3;
            ST_T3: begin
                case (cur_class_s)
                    CLS_NOP:            state_nxt_s = end_halt_s ? ST_HALT : ST_T0;
                    CLS_HALT, CLS_ILL:  state_nxt_s = ST_HALT;
                    default:            state_nxt_s = ST_T4;
                endcase
            end
            ST_T4:   state_nxt_s = ST_T5;
            ST_T5: begin
                case (cur_class_s)
                    CLS_LD, CLS_ST:                   state_nxt_s = ST_T6;
                    CLS_LDI, CLS_ADDI, CLS_ANDI, CLS_ORI:
                                                      state_nxt_s = end_halt_s ? ST_HALT : ST_T0;
                    default:                          state_nxt_s = ST_HALT;
                endcase
            end
            ST_T6: begin
                case (cur_class_s)
                    CLS_LD: begin
                        if (timeout_s) begin
                            state_nxt_s = ST_HALT;
                        end else if (Mem_Ready) begin
                            state_nxt_s = ST_T7;
                        end else begin
                            state_nxt_s = ST_T6;
                        end
                    end
                    CLS_ST:  state_nxt_s = ST_T7;
                    default: state_nxt_s = ST_HALT;
                endcase
            end
            ST_T7: begin
                case (cur_class_s)
                    CLS_LD: state_nxt_s = end_halt_s ? ST_HALT : ST_T0;
                    CLS_ST: begin
                        if (timeout_s) begin
                            state_nxt_s = ST_HALT;
                        end else if (Mem_Ready) begin
                            state_nxt_s = end_halt_s ? ST_HALT : ST_T0;
                        end else begin
                            state_nxt_s = ST_T7;
                        end
                    end
                    default: state_nxt_s = ST_HALT;
                endcase
            end
            ST_HALT: state_nxt_s = ST_HALT;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Moore output decode from the current control step.
    always_comb begin
        CONTROL = CTRL_W'(ALU_ADD);
        IncPC   = 1'b0;
        Read    = 1'b0;
        Write   = 1'b0;
        PC_Out  = 1'b0;
        MDR_Out = 1'b0;
        ZLO_Out = 1'b0;
        C_Out   = 1'b0;
        R_Out   = 1'b0;
        BA_Out  = 1'b0;
        PC_In   = 1'b0;
        MDR_In  = 1'b0;
        MAR_In  = 1'b0;
        IR_In   = 1'b0;
        Y_In    = 1'b0;
        ZLO_In  = 1'b0;
        R_In    = 1'b0;
        G_RA    = 1'b0;
        G_RB    = 1'b0;
        Run     = 1'b0;
        case (state_r)
            ST_T0: begin
                Run    = 1'b1;
                PC_Out = 1'b1;
                MAR_In = 1'b1;
                IncPC  = 1'b1;
            end
            ST_T1: begin
                Run    = 1'b1;
                Read   = 1'b1;
                MDR_In = 1'b1;
            end
            ST_T2: begin
                Run     = 1'b1;
                MDR_Out = 1'b1;
                IR_In   = 1'b1;
            end
            ST_T3: begin
                Run = 1'b1;
                case (cur_class_s)
                    CLS_LD, CLS_LDI, CLS_ST: begin
                        G_RB   = 1'b1;
                        BA_Out = 1'b1;
                        Y_In   = 1'b1;
                    end
                    CLS_ADDI, CLS_ANDI, CLS_ORI: begin
                        G_RB  = 1'b1;
                        R_Out = 1'b1;
                        Y_In  = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
            ST_T4: begin
                Run     = 1'b1;
                C_Out   = 1'b1;
                ZLO_In  = 1'b1;
                CONTROL = CTRL_W'(alu_code(cur_class_s));
            end
            ST_T5: begin
                Run = 1'b1;
                case (cur_class_s)
                    CLS_LD, CLS_ST: begin
                        ZLO_Out = 1'b1;
                        MAR_In  = 1'b1;
                    end
                    CLS_LDI, CLS_ADDI, CLS_ANDI, CLS_ORI: begin
                        ZLO_Out = 1'b1;
                        G_RA    = 1'b1;
                        R_In    = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
            ST_T6: begin
                Run = 1'b1;
                case (cur_class_s)
                    CLS_LD: begin
                        Read   = 1'b1;
                        MDR_In = 1'b1;
                    end
                    CLS_ST: begin
                        G_RA   = 1'b1;
                        R_Out  = 1'b1;
                        MDR_In = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
            ST_T7: begin
                Run = 1'b1;
                case (cur_class_s)
                    CLS_LD: begin
                        MDR_Out = 1'b1;
                        G_RA    = 1'b1;
                        R_In    = 1'b1;
                    end
                    CLS_ST:  Write = 1'b1;
                    default: begin
                    end
                endcase
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Testbench: tb_control_sequencer
// Directed instruction sequences. For each instruction the bench expands the
// control-step table (fetch, execute, memory waits, stop/clear/trap outcome)
// into a per-cycle list of expected output vectors; a compare process checks
// the DUT against that list every cycle.
module tb_control_sequencer;

    localparam int MEM_TIMEOUT = 15;

    localparam logic [17:0] B_INCPC  = 18'd1 << 17;
    localparam logic [17:0] B_READ   = 18'd1 << 16;
    localparam logic [17:0] B_WRITE  = 18'd1 << 15;
    localparam logic [17:0] B_PCOUT  = 18'd1 << 14;
    localparam logic [17:0] B_MDROUT = 18'd1 << 13;
    localparam logic [17:0] B_ZLOOUT = 18'd1 << 12;
    localparam logic [17:0] B_COUT   = 18'd1 << 11;
    localparam logic [17:0] B_ROUT   = 18'd1 << 10;
    localparam logic [17:0] B_BAOUT  = 18'd1 << 9;
    localparam logic [17:0] B_MDRIN  = 18'd1 << 7;
    localparam logic [17:0] B_MARIN  = 18'd1 << 6;
    localparam logic [17:0] B_IRIN   = 18'd1 << 5;
    localparam logic [17:0] B_YIN    = 18'd1 << 4;
    localparam logic [17:0] B_ZLOIN  = 18'd1 << 3;
    localparam logic [17:0] B_RIN    = 18'd1 << 2;
    localparam logic [17:0] B_GRA    = 18'd1 << 1;
    localparam logic [17:0] B_GRB    = 18'd1 << 0;

    logic        Clock = 1'b0;
    logic        Clear = 1'b1;
    logic        Start = 1'b0;
    logic        Stop  = 1'b0;
    logic [31:0] IR    = 32'd0;
    logic        Mem_Ready = 1'b1;
    logic [4:0]  CONTROL;
    logic IncPC, Read, Write, PC_Out, MDR_Out, ZLO_Out, C_Out, R_Out, BA_Out;
    logic PC_In, MDR_In, MAR_In, IR_In, Y_In, ZLO_In, R_In, G_RA, G_RB;
    logic Run, Illegal, Mem_Err;

    control_sequencer #(
        .OPC_W(5), .CTRL_W(5), .MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(4)
    ) dut (
        .Clock(Clock), .Clear(Clear), .Start(Start), .Stop(Stop), .IR(IR),
        .Mem_Ready(Mem_Ready), .CONTROL(CONTROL),
        .IncPC(IncPC), .Read(Read), .Write(Write), .PC_Out(PC_Out),
        .MDR_Out(MDR_Out), .ZLO_Out(ZLO_Out), .C_Out(C_Out), .R_Out(R_Out),
        .BA_Out(BA_Out), .PC_In(PC_In), .MDR_In(MDR_In), .MAR_In(MAR_In),
        .IR_In(IR_In), .Y_In(Y_In), .ZLO_In(ZLO_In), .R_In(R_In),
        .G_RA(G_RA), .G_RB(G_RB), .Run(Run), .Illegal(Illegal), .Mem_Err(Mem_Err)
    );

    always #5 Clock = ~Clock;

    logic [25:0] dut_vec;
    assign dut_vec = {Run, Illegal, Mem_Err, CONTROL,
                      IncPC, Read, Write, PC_Out, MDR_Out, ZLO_Out, C_Out, R_Out, BA_Out,
                      PC_In, MDR_In, MAR_In, IR_In, Y_In, ZLO_In, R_In, G_RA, G_RB};

    int tests = 0;
    int fails = 0;
    int cyc_no = 0;
    logic [25:0] exp_q[$];

    // Model state.
    bit          ill_m = 1'b0;
    bit          err_m = 1'b0;
    int          n_cyc;
    int          stop_idx;
    int          clr_idx;
    bit          aborted;
    logic [31:0] ir_cur = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc_no, act, expv);
        end
    endtask

    // Compare process: one expected vector per cycle, sampled mid-cycle.
    initial begin
        logic [25:0] e;
        forever begin
            @(negedge Clock);
            #1;
            cyc_no++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("outputs", {6'd0, dut_vec}, {6'd0, e});
            end
        end
    end

    // One instruction cycle: drive inputs for this cycle and record its expected outputs.
    task automatic cyc(input logic [17:0] stb, input logic [4:0] ctl, input logic rdy);
        if (aborted) return;
        @(negedge Clock);
        Start     = 1'b0;
        Stop      = (n_cyc == stop_idx);
        Clear     = (n_cyc == clr_idx);
        Mem_Ready = rdy;
        IR        = ir_cur;
        exp_q.push_back({1'b1, ill_m, err_m, ctl, stb});
        if (n_cyc == clr_idx) begin
            aborted = 1'b1;
            ill_m   = 1'b0;
            err_m   = 1'b0;
        end
        n_cyc++;
    endtask

    // Memory wait: d not-ready cycles then ready; d beyond the timeout traps.
    task automatic wait_cycles(input logic [17:0] stb, input int d, output bit to);
        to = 1'b0;
        if (d > MEM_TIMEOUT) begin
            for (int i = 0; i <= MEM_TIMEOUT; i++) cyc(stb, 5'd0, 1'b0);
            to = !aborted;
        end else begin
            for (int i = 0; i < d; i++) cyc(stb, 5'd0, 1'b0);
            cyc(stb, 5'd0, 1'b1);
        end
    endtask

    // Idle/halt cycles (Run=0, no strobes).
    task automatic quiet(input logic st, input logic rdy, input int k);
        for (int i = 0; i < k; i++) begin
            @(negedge Clock);
            Start = st; Stop = 1'b0; Clear = 1'b0; Mem_Ready = rdy;
            exp_q.push_back({1'b0, ill_m, err_m, 5'd0, 18'd0});
        end
    endtask

    task automatic do_clear();
        @(negedge Clock);
        Start = 1'b0; Stop = 1'b0; Clear = 1'b1; Mem_Ready = 1'b1;
        exp_q.push_back({1'b0, ill_m, err_m, 5'd0, 18'd0});
        ill_m = 1'b0;
        err_m = 1'b0;
    endtask

    // Full instruction from T0. status: 0 -> next is T0, 1 -> HALT, 2 -> cleared to IDLE.
    task automatic instr(input logic [31:0] ir, input int dfetch, input int dexec,
                         input int sidx, input int cidx, output int status);
        logic [4:0] op;
        bit to;
        bit trap;
        ir_cur = ir; n_cyc = 0; stop_idx = sidx; clr_idx = cidx; aborted = 1'b0;
        op = ir[31:27];
        trap = 1'b0;
        to = 1'b0;
        cyc(B_PCOUT | B_MARIN | B_INCPC, 5'd0, 1'b1);
        wait_cycles(B_READ | B_MDRIN, dfetch, to);
        if (!to) begin
            cyc(B_MDROUT | B_IRIN, 5'd0, 1'b1);
            case (op)
                5'd0, 5'd1, 5'd2: begin
                    cyc(B_GRB | B_BAOUT | B_YIN, 5'd0, 1'b1);
                    cyc(B_COUT | B_ZLOIN, 5'd0, 1'b1);
                    if (op == 5'd1) begin
                        cyc(B_ZLOOUT | B_GRA | B_RIN, 5'd0, 1'b1);
                    end else begin
                        cyc(B_ZLOOUT | B_MARIN, 5'd0, 1'b1);
                        if (op == 5'd0) begin
                            wait_cycles(B_READ | B_MDRIN, dexec, to);
                            if (!to) cyc(B_MDROUT | B_GRA | B_RIN, 5'd0, 1'b1);
                        end else begin
                            cyc(B_GRA | B_ROUT | B_MDRIN, 5'd0, 1'b1);
                            wait_cycles(B_WRITE, dexec, to);
                        end
                    end
                end
                5'd12, 5'd13, 5'd14: begin
                    cyc(B_GRB | B_ROUT | B_YIN, 5'd0, 1'b1);
                    cyc(B_COUT | B_ZLOIN, (op == 5'd13) ? 5'b00101 :
                                          (op == 5'd14) ? 5'b00110 : 5'b00000, 1'b1);
                    cyc(B_ZLOOUT | B_GRA | B_RIN, 5'd0, 1'b1);
                end
                5'd30: cyc(18'd0, 5'd0, 1'b1);
                5'd31: begin
                    cyc(18'd0, 5'd0, 1'b1);
                    trap = 1'b1;
                end
                default: begin
                    cyc(18'd0, 5'd0, 1'b1);
                    if (!aborted) ill_m = 1'b1;
                    trap = 1'b1;
                end
            endcase
        end
        if (aborted) begin
            status = 2;
        end else if (to) begin
            err_m = 1'b1;
            status = 1;
        end else if (trap || (sidx >= 0 && sidx < n_cyc)) begin
            status = 1;
        end else begin
            status = 0;
        end
    endtask

    task automatic start_pulse();
        @(negedge Clock);
        Start = 1'b1; Stop = 1'b0; Clear = 1'b0; Mem_Ready = 1'b1;
        exp_q.push_back({1'b0, ill_m, err_m, 5'd0, 18'd0});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        // Reset: first cycle's outputs are unknown, so nothing is expected for it.
        @(negedge Clock);
        Clear = 1'b1;
        do_clear();
        quiet(1'b0, 1'b0, 2);
        #2 chk("reset_all_zero", {6'd0, dut_vec}, 32'd0);

        // ldi R1,85 followed by a straight run of instructions.
        start_pulse();
        instr(32'h08800055, 0, 0, -1, -1, st);
        chk("ldi_len", n_cyc, 6);
        chk("ldi_next_t0", st, 0);
        instr(32'h00000000, 0, 3, -1, -1, st);
        chk("ld_delay3_len", n_cyc, 11);
        instr(32'h10000000, 0, 0, -1, -1, st);
        chk("st_len", n_cyc, 8);
        instr(32'h60000000, 2, 0, -1, -1, st);
        instr(32'h68000000, 0, 0, -1, -1, st);
        instr(32'h70000000, 1, 0, -1, -1, st);
        instr(32'h10000000, 0, 2, -1, -1, st);
        instr(32'hF0000000, 0, 0, -1, -1, st);
        chk("nop_len", n_cyc, 4);
        instr(32'hF8000000, 0, 0, -1, -1, st);
        chk("halt_status", st, 1);
        quiet(1'b1, 1'b0, 3);
        #2 chk("halt_run", {31'd0, Run}, 32'd0);
        do_clear();
        quiet(1'b0, 1'b1, 1);

        // Fetch timeout: Mem_Ready held low in T1.
        start_pulse();
        instr(32'h00000000, 100, 0, -1, -1, st);
        chk("timeout_len", n_cyc, 17);
        quiet(1'b0, 1'b0, 2);
        #2 chk("timeout_mem_err", {31'd0, Mem_Err}, 32'd1);
        chk("timeout_read_low", {31'd0, Read}, 32'd0);
        do_clear();
        quiet(1'b0, 1'b1, 1);
        #2 chk("clear_mem_err", {31'd0, Mem_Err}, 32'd0);

        // Undefined opcode 7.
        start_pulse();
        instr(32'h38000000, 0, 0, -1, -1, st);
        quiet(1'b0, 1'b1, 1);
        #2 chk("illegal_set", {31'd0, Illegal}, 32'd1);
        do_clear();
        quiet(1'b0, 1'b1, 1);
        #2 chk("illegal_cleared", {31'd0, Illegal}, 32'd0);

        // st write timeout in T7.
        start_pulse();
        instr(32'h10000000, 0, 40, -1, -1, st);
        chk("st_timeout_status", st, 1);
        quiet(1'b0, 1'b1, 1);
        do_clear();
        quiet(1'b0, 1'b1, 1);

        // Stop in T4 of addi, then Clear in the middle of a ld T6 wait.
        start_pulse();
        instr(32'h60000000, 0, 0, 4, -1, st);
        chk("stop_status", st, 1);
        quiet(1'b0, 1'b1, 2);
        do_clear();
        quiet(1'b0, 1'b1, 1);
        start_pulse();
        instr(32'h00000000, 0, 5, -1, 8, st);
        chk("clear_status", st, 2);
        quiet(1'b0, 1'b1, 1);
        #2 chk("clr_all_zero", {6'd0, dut_vec}, 32'd0);
        quiet(1'b0, 1'b1, 1);

        // A ld after the mid-wait clear starts with a fresh wait count.
        start_pulse();
        instr(32'h00000000, 3, 14, -1, -1, st);
        chk("ld_after_clear", st, 0);
        quiet(1'b0, 1'b1, 0);

        @(negedge Clock);
        Start = 1'b0;
        #3;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
